// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte buffer between the core and the UART transmitter.
// Circular storage feeds a registered AXI-stream output stage; an optional
// carriage return is inserted ahead of every line feed.
`timescale 1ns/1ps

module uart_tx_fifo #(
   parameter int DEPTH = 16,
   parameter bit CRLF  = 1'b1
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     flush,
   output logic [7:0]               m_axis_tdata,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready
);

   localparam int            AW     = $clog2(DEPTH);
   localparam logic [AW:0]   C_FULL = (AW+1)'(DEPTH);
   localparam logic [7:0]    C_LF   = 8'h0A;
   localparam logic [7:0]    C_CR   = 8'h0D;

   typedef enum logic [1:0] {
      ST_EMPTY  = 2'd0,
      ST_DATA   = 2'd1,
      ST_CR_INS = 2'd2
   } state_t;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic [7:0]    r_tdata;
   state_t        r_state;
   state_t        w_state_next;

   logic          w_full;
   logic          w_empty;
   logic          w_xfer;
   logic          w_wr_acc;
   logic          w_pop;
   logic          w_load;
   logic [7:0]    w_head;
   logic [7:0]    w_load_data;

   // Acceptance is decided on the current-cycle fill level, so a pop in the
   // same cycle never makes room for a write that arrived while full.
   assign w_full   = (r_count == C_FULL);
   assign w_empty  = (r_count == '0);
   assign w_xfer   = (r_state != ST_EMPTY) && m_axis_tready;
   assign w_wr_acc = wr_en && !w_full;
   assign w_head   = r_mem[r_rd_ptr];

   assign full          = w_full;
   assign count         = r_count;
   assign overflow      = r_overflow;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tvalid = (r_state != ST_EMPTY);

   // Next output-stage state: decide whether to load the output register,
   // what to load, and whether the head byte leaves storage.
   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_load_data  = r_tdata;
      w_pop        = 1'b0;
      case (r_state)
         ST_CR_INS: begin
            // The held CR was taken; the LF it guards is still at the head.
            // Reload it directly so it is not expanded a second time.
            if (w_xfer) begin
               w_load       = 1'b1;
               w_load_data  = C_LF;
               w_pop        = 1'b1;
               w_state_next = ST_DATA;
            end
         end
         default: begin
            if (!w_empty && (r_state == ST_EMPTY || w_xfer)) begin
               w_load = 1'b1;
               if (CRLF && w_head == C_LF) begin
                  w_load_data  = C_CR;
                  w_state_next = ST_CR_INS;
               end else begin
                  w_load_data  = w_head;
                  w_pop        = 1'b1;
                  w_state_next = ST_DATA;
               end
            end else if (w_xfer) begin
               w_state_next = ST_EMPTY;
            end
         end
      endcase
   end

   // Control state: pointers, fill level, sticky overflow, output stage.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_tdata    <= 8'h00;
         r_state    <= ST_EMPTY;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_state    <= ST_EMPTY;
      end else begin
         if (wr_en && w_full) begin
            r_overflow <= 1'b1;
         end
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr_acc && !w_pop) begin
            r_count <= r_count + (AW+1)'(1);
         end else if (!w_wr_acc && w_pop) begin
            r_count <= r_count - (AW+1)'(1);
         end
         if (w_load) begin
            r_tdata <= w_load_data;
         end
         r_state <= w_state_next;
      end
   end

   // Storage array: write-only here, read into the output register above.
   always_ff @(posedge clk) begin
      if (nrst && !flush && w_wr_acc) begin
         r_mem[r_wr_ptr] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo. A queue-based model
// predicts fill level and the expanded output stream; a monitor compares
// every AXI transfer against the expected byte queue.
`timescale 1ns/1ps

module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
   localparam bit CRLF  = 1'b1;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          nrst;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_en = 1'b0;
   logic          flush = 1'b0;
   logic          m_axis_tready = 1'b0;
   logic          full;
   logic [CW-1:0] count;
   logic          overflow;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;

   int checks = 0;
   int passed = 0;

   // Expected output stream (scoreboard) and reference model state.
   logic [7:0] sb_q[$];
   logic [7:0] m_sq[$];
   bit         m_valid = 1'b0;
   bit         m_cr    = 1'b0;
   bit         m_ovf   = 1'b0;
   logic [7:0] m_data  = 8'h00;

   bit         prev_stall = 1'b0;
   logic [7:0] prev_data  = 8'h00;

   uart_tx_fifo #(.DEPTH(DEPTH), .CRLF(CRLF)) dut (
      .clk           (clk),
      .nrst          (nrst),
      .wr_data       (wr_data),
      .wr_en         (wr_en),
      .full          (full),
      .count         (count),
      .overflow      (overflow),
      .flush         (flush),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference model: advance by one clock edge with the given inputs.
   task automatic model_step(input bit w, input logic [7:0] d, input bit rdy, input bit fl);
      int sz;
      bit acc;
      bit xfer;
      if (fl) begin
         m_sq.delete();
         sb_q.delete();
         m_valid = 1'b0;
         m_cr    = 1'b0;
         m_ovf   = 1'b0;
         return;
      end
      sz   = m_sq.size();
      acc  = w && (sz < DEPTH);
      xfer = m_valid && rdy;
      if (w && !acc) m_ovf = 1'b1;
      if (xfer && m_cr) begin
         m_data = 8'h0A;
         m_sq.delete(0);
         m_cr = 1'b0;
      end else if (sz > 0 && (!m_valid || xfer)) begin
         if (CRLF && m_sq[0] == 8'h0A) begin
            m_data = 8'h0D;
            m_cr   = 1'b1;
         end else begin
            m_data = m_sq[0];
            m_sq.delete(0);
            m_cr   = 1'b0;
         end
         m_valid = 1'b1;
      end else if (xfer) begin
         m_valid = 1'b0;
      end
      if (acc) begin
         m_sq.push_back(d);
         if (CRLF && d == 8'h0A) sb_q.push_back(8'h0D);
         sb_q.push_back(d);
      end
   endtask

   task automatic model_reset();
      m_sq.delete();
      sb_q.delete();
      m_valid = 1'b0;
      m_cr    = 1'b0;
      m_ovf   = 1'b0;
      m_data  = 8'h00;
   endtask

   // One transaction: check state after the last edge, then drive inputs
   // for the next edge and advance the model.
   task automatic cycle(input bit w, input logic [7:0] d, input bit rdy, input bit fl);
      @(posedge clk);
      #2;
      check("count", count, m_sq.size());
      check("full", full, m_sq.size() == DEPTH);
      check("overflow", overflow, m_ovf);
      check("tvalid", m_axis_tvalid, m_valid);
      if (m_valid) check("tdata", m_axis_tdata, m_data);
      $display("cyc t=%0t wr=%0b d=%02h rdy=%0b fl=%0b | cnt=%0d v=%0b q=%02h", $time, w, d, rdy, fl,
               count, m_axis_tvalid, m_axis_tdata);
      wr_en         = w;
      wr_data       = d;
      m_axis_tready = rdy;
      flush         = fl;
      model_step(w, d, rdy, fl);
   endtask

   // Monitor: compare each transfer against the scoreboard and check that
   // a stalled byte stays put.
   always @(negedge clk) begin
      if (!nrst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, prev_data);
         end
         if (m_axis_tvalid && m_axis_tready && !flush) begin
            if (sb_q.size() == 0) begin
               checks++;
               $display("FAIL stream_extra: got 0x%02h, expected no byte (t=%0t)", m_axis_tdata, $time);
            end else begin
               check("stream", m_axis_tdata, sb_q.pop_front());
            end
         end
         prev_stall = m_axis_tvalid && !m_axis_tready && !flush;
         prev_data  = m_axis_tdata;
      end
   end

   initial begin
      bit         rw;
      bit         rr;
      bit         rf;
      logic [7:0] rd;

      // Reset state
      nrst = 1'b1;
      #1 nrst = 1'b0;
      #1;
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 8'h00);
      check("rst_count", count, 0);
      check("rst_full", full, 0);
      check("rst_overflow", overflow, 0);
      model_reset();
      repeat (2) @(negedge clk);
      #1 nrst = 1'b1;

      // Single byte latency and drop of tvalid after the transfer
      cycle(1, 8'h41, 1, 0);
      cycle(0, 8'h00, 1, 0);
      check("t1_count_n", count, 1);
      check("t1_valid_n", m_axis_tvalid, 0);
      cycle(0, 8'h00, 1, 0);
      check("t1_valid_n1", m_axis_tvalid, 1);
      check("t1_data_n1", m_axis_tdata, 8'h41);
      cycle(0, 8'h00, 1, 0);
      check("t1_valid_done", m_axis_tvalid, 0);
      check("t1_count_done", count, 0);

      // Fill to full while stalled, then overflow, then drain with wrap
      for (int i = 0; i <= 16; i++) cycle(1, 8'(i), 0, 0);
      cycle(1, 8'h11, 0, 0);
      check("t2_count_full", count, 16);
      check("t2_full", full, 1);
      check("t2_hold_first", m_axis_tdata, 8'h00);
      cycle(0, 8'h00, 1, 0);
      check("t2_overflow", overflow, 1);
      check("t2_count_after_ovf", count, 16);
      repeat (25) cycle(0, 8'h00, 1, 0);

      // Flush clears overflow; full with simultaneous pop and write
      cycle(0, 8'h00, 0, 1);
      cycle(0, 8'h00, 0, 0);
      check("t5_ovf_cleared", overflow, 0);
      for (int i = 0; i <= 16; i++) cycle(1, 8'(8'h20 + i), 0, 0);
      cycle(1, 8'h55, 1, 0);
      check("t5_full_before", full, 1);
      cycle(0, 8'h00, 0, 0);
      check("t5_count_15", count, 15);
      check("t5_overflow", overflow, 1);
      check("t5_full_after", full, 0);
      repeat (20) cycle(0, 8'h00, 1, 0);

      // CR insertion before consecutive line feeds
      cycle(1, 8'h48, 1, 0);
      cycle(1, 8'h0A, 1, 0);
      cycle(1, 8'h0A, 1, 0);
      cycle(1, 8'h49, 1, 0);
      repeat (10) cycle(0, 8'h00, 1, 0);
      check("t3_drained", m_axis_tvalid, 0);

      // Line feed under random backpressure
      cycle(1, 8'h0A, 0, 0);
      for (int i = 0; i < 20; i++) cycle(0, 8'h00, 1'($urandom_range(0, 1)), 0);
      repeat (6) cycle(0, 8'h00, 1, 0);

      // Randomized traffic: writes, line feeds, backpressure, rare flush
      for (int i = 0; i < 400; i++) begin
         rw = 1'($urandom_range(0, 1));
         rd = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
         rr = 1'($urandom_range(0, 1));
         rf = ($urandom_range(0, 63) == 0);
         cycle(rw, rd, rr, rf);
      end
      repeat (40) cycle(0, 8'h00, 1, 0);

      // Mid-stream flush with a simultaneous write
      cycle(1, 8'h61, 0, 0);
      cycle(1, 8'h62, 0, 0);
      cycle(1, 8'h63, 0, 0);
      cycle(1, 8'h77, 0, 1);
      cycle(0, 8'h00, 0, 0);
      check("t6_flush_count", count, 0);
      check("t6_flush_valid", m_axis_tvalid, 0);
      check("t6_flush_ovf", overflow, 0);

      // Asynchronous reset while a byte is held on the output
      cycle(1, 8'h64, 0, 0);
      cycle(1, 8'h65, 0, 0);
      cycle(0, 8'h00, 0, 0);
      cycle(0, 8'h00, 1, 0);
      #1 nrst = 1'b0;
      #1;
      check("t6_rst_valid", m_axis_tvalid, 0);
      check("t6_rst_data", m_axis_tdata, 8'h00);
      check("t6_rst_count", count, 0);
      wr_en = 1'b0;
      flush = 1'b0;
      m_axis_tready = 1'b0;
      model_reset();
      @(negedge clk);
      #1 nrst = 1'b1;

      // Traffic after reset, then drain
      cycle(1, 8'h0A, 1, 0);
      cycle(1, 8'h7A, 1, 0);
      repeat (8) cycle(0, 8'h00, 1, 0);
      check("drain_left", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
